mmio_console_tx: RTL

//  Memory-mapped console transmitter on the processor data bus, peer of the data RAM.

---
 rtl/mmio_console_tx_pkg.sv | 42 ++++
 rtl/mmio_console_tx_if.sv | 34 +++
 rtl/mmio_console_tx_sync_fifo.sv | 76 +++++++
 rtl/mmio_console_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_console_tx_pkg.sv
// Shared definitions for the memory-mapped console transmitter.
//   - register offsets decoded from addr_in[3:2]
//   - STATUS bit positions and the overflow-clear bit used on STATUS writes
//   - transmitter FSM state type
//   - status_word(): assembles the 32-bit STATUS read value
package mmio_console_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int unsigned ST_BIT_FULL    = 0;
    localparam int unsigned ST_BIT_EMPTY   = 1;
    localparam int unsigned ST_BIT_BUSY    = 2;
    localparam int unsigned ST_BIT_OVF     = 3;
    localparam int unsigned ST_CNT_LSB     = 4;
    localparam int unsigned ST_OVF_CLR_BIT = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] status_word(
        input logic [7:0] count,
        input logic       overflow,
        input logic       busy,
        input logic       empty,
        input logic       full
    );
        logic [31:0] w;
        w                     = '0;
        w[ST_CNT_LSB +: 8]    = count;
        w[ST_BIT_OVF]         = overflow;
        w[ST_BIT_BUSY]        = busy;
        w[ST_BIT_EMPTY]       = empty;
        w[ST_BIT_FULL]        = full;
        return w;
    endfunction

endpackage

// File: rtl/mmio_console_tx_if.sv
// Processor data-bus port, identical in shape to the data RAM port so the
// core's bus decode can drive both in parallel.
//   addr_in  [31:0] byte address       data_in [31:0] store data
//   size_in  [1:0]  access size        we_in / re_in  store / load strobes
//   data_out [31:0] load data (returned by the slave)
// Modports: master (core side), slave (peripheral side).
interface mmio_console_tx_if;

    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [1:0]  size_in;
    logic        we_in;
    logic        re_in;
    logic [31:0] data_out;

    modport master (
        output addr_in,
        output data_in,
        output size_in,
        output we_in,
        output re_in,
        input  data_out
    );

    modport slave (
        input  addr_in,
        input  data_in,
        input  size_in,
        input  we_in,
        input  re_in,
        output data_out
    );

endinterface

// File: rtl/mmio_console_tx_sync_fifo.sv
// Synchronous FIFO of 2**LOG entries of WIDTH bits.
//   clock, reset        system clock, synchronous active-high reset
//   push_i, wdata_i     enqueue request and data
//   pop_i, rdata_o      dequeue request; rdata_o shows the head combinationally
//   full_o, empty_o     occupancy flags
//   count_o [LOG:0]     number of stored entries
// A push while full is accepted when a pop happens in the same cycle.
// Pops on an empty FIFO are ignored.
module mmio_console_tx_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LOG   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LOG:0]     count_o
);

    localparam int unsigned DEPTH = 1 << LOG;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LOG-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LOG-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LOG:0]     count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (LOG+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    // When full, the slot being freed by a same-cycle pop is the one written.
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mmio_console_tx.sv
// Memory-mapped console transmitter, peer of the data RAM on the core bus.
// Stores to TXDATA queue a character in a FIFO; an 8N1 UART FSM drains it.
//   clock  system clock           reset  synchronous, active-high
//   bus    data-bus slave port (addr/data/size/we/re in, data_out out)
//   tx     UART serial output, idle high
// Register map (addr_in[31:16] == IO_ADDR, register = addr_in[3:2]):
//   0x0 TXDATA  write: push data_in[7:0]
//   0x4 STATUS  read : {20'b0, count[7:0], overflow, busy, empty, full}
//               write: data_in[4]=1 clears sticky overflow
//   0x8/0xC     reserved, read 0, writes ignored
// Loads return on the falling edge, matching the data RAM timing.
module mmio_console_tx
    import mmio_console_tx_pkg::*;
#(
    parameter logic [15:0] IO_ADDR      = 16'hFFFF,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_LOG     = 3
) (
    input  logic                clock,
    input  logic                reset,
    mmio_console_tx_if.slave    bus,
    output logic                tx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Bus decode
    logic       sel;
    logic [1:0] reg_idx;
    logic       wr_tx, wr_status, rd_status;

    assign sel       = (bus.addr_in[31:16] == IO_ADDR);
    assign reg_idx   = bus.addr_in[3:2];
    assign wr_tx     = bus.we_in & sel & (reg_idx == REG_TXDATA);
    assign wr_status = bus.we_in & sel & (reg_idx == REG_STATUS);
    assign rd_status = bus.re_in & sel & (reg_idx == REG_STATUS);

    // Access size, the upper data byte lanes and the byte offset do not
    // affect this block.
    logic unused_bits;
    assign unused_bits = ^{bus.size_in, bus.addr_in[15:4], bus.addr_in[1:0],
                           bus.data_in[31:8]};

    // FIFO
    logic              fifo_pop;
    logic [7:0]        fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [FIFO_LOG:0] fifo_count;

    mmio_console_tx_sync_fifo #(
        .WIDTH (8),
        .LOG   (FIFO_LOG)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (wr_tx),
        .wdata_i (bus.data_in[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sticky overflow: a dropped byte in the same cycle beats a clear.
    logic overflow_q, overflow_d;
    logic ovf_event;

    assign ovf_event = wr_tx & fifo_full & ~fifo_pop;

    always_comb begin
        overflow_d = overflow_q;
        if (ovf_event) begin
            overflow_d = 1'b1;
        end else if (wr_status && bus.data_in[ST_OVF_CLR_BIT]) begin
            overflow_d = 1'b0;
        end
    end

    // Transmit FSM and baud counter
    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy;

    assign busy = (state_q != TX_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        tx_d      = 1'b1;

        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    cnt_d    = '0;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = TX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // The line level is registered from the next state, so it changes on
        // the same edge as the state and never glitches between flops.
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx = tx_q;

    // Load path on the falling edge, same half-cycle latency as the data RAM.
    logic [31:0] data_out_q;

    always_ff @(negedge clock) begin
        if (reset) begin
            data_out_q <= '0;
        end else if (rd_status) begin
            data_out_q <= status_word(8'(fifo_count), overflow_q, busy,
                                      fifo_empty, fifo_full);
        end else begin
            data_out_q <= '0;
        end
    end

    assign bus.data_out = data_out_q;

endmodule
